// File: rtl/alu_rr_arbiter_if.sv
// Bundle between the requester blocks / ALU and the round-robin arbiter.
// The lock bus exists only when ARB_LOCK_EN is defined.
interface alu_arb_if;
  logic [3:0] req;
`ifdef ARB_LOCK_EN
  logic [3:0] lock;
`endif
  logic       alu_done;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       alu_start;
  logic       busy;
  logic       timeout_err;

`ifdef ARB_LOCK_EN
  modport master (output req, output lock, output alu_done,
                  input sel, input gnt, input alu_start, input busy, input timeout_err);
  modport slave  (input req, input lock, input alu_done,
                  output sel, output gnt, output alu_start, output busy, output timeout_err);
`else
  modport master (output req, output alu_done,
                  input sel, input gnt, input alu_start, input busy, input timeout_err);
  modport slave  (input req, input alu_done,
                  output sel, output gnt, output alu_start, output busy, output timeout_err);
`endif
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between 4 requesters.
// IDLE picks a winner starting at ptr, START pulses alu_start, WAIT holds
// the grant until alu_done or a timeout (TIMEOUT=0 disables the timeout).
// Optional feature macro: ARB_LOCK_EN (a locked winner is re-granted on
// alu_done without advancing ptr).
module alu_rr_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input logic      clk,
  input logic      rst_n,
  alu_arb_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]      state_r, state_s, state_n_s;
  logic [1:0]      ptr_r, ptr_s;
  logic [1:0]      sel_r, sel_n_s;
  logic [TO_W-1:0] cnt_r, cnt_s;
  logic [3:0]      gnt_r;
  logic            alu_start_r;
  logic            busy_r;
  logic            timeout_err_r;
  logic            terr_s;
  logic            arb_s;
  logic            to_hit_s;
  logic            relock_s;
  logic [2:0]      win_s;

  // First set request bit scanning from p upward (mod 4); {valid, index}.
  function automatic logic [2:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // 2-to-4 decode of the select.
  function automatic logic [3:0] decode_sel(input logic [1:0] s);
    return 4'b0001 << s;
  endfunction

  assign to_hit_s = TO_EN && (cnt_r == TO_LAST);

`ifdef ARB_LOCK_EN
  assign relock_s = bus.lock[sel_r] & bus.req[sel_r];
`else
  assign relock_s = 1'b0;
`endif

  // Next-state, pointer, counter and arbitration decision.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    terr_s  = 1'b0;
    arb_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        arb_s = 1'b1;
      end
      ST_START: begin
        state_s = ST_WAIT;
        cnt_s   = {TO_W{1'b0}};
      end
      ST_WAIT: begin
        cnt_s = cnt_r + TO_W'(1);
        if (bus.alu_done) begin
          // alu_done wins over a coincident timeout: no error pulse
          cnt_s = {TO_W{1'b0}};
          if (relock_s) begin
            state_s = ST_START;
          end else begin
            ptr_s = sel_r + 2'd1;
            arb_s = 1'b1;
          end
        end else if (to_hit_s) begin
          cnt_s  = {TO_W{1'b0}};
          terr_s = 1'b1;
          ptr_s  = sel_r + 2'd1;
          arb_s  = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Arbitration uses the freshly advanced pointer so release and re-grant
    // happen in the same cycle.
    win_s     = pick_winner(bus.req, ptr_s);
    state_n_s = arb_s ? (win_s[2] ? ST_START : ST_IDLE) : state_s;
    sel_n_s   = (arb_s && win_s[2]) ? win_s[1:0] : sel_r;
  end

  // State and registered outputs; async reset abandons any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      ptr_r         <= 2'd0;
      sel_r         <= 2'd0;
      cnt_r         <= {TO_W{1'b0}};
      gnt_r         <= 4'b0000;
      alu_start_r   <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_n_s;
      ptr_r         <= ptr_s;
      sel_r         <= sel_n_s;
      cnt_r         <= cnt_s;
      gnt_r         <= (state_n_s != ST_IDLE) ? decode_sel(sel_n_s) : 4'b0000;
      alu_start_r   <= (state_n_s == ST_START);
      busy_r        <= (state_n_s != ST_IDLE);
      timeout_err_r <= terr_s;
    end
  end

  assign bus.sel         = sel_r;
  assign bus.gnt         = gnt_r;
  assign bus.alu_start   = alu_start_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter (TIMEOUT=4). Directed scenarios
// plus randomized traffic against a transaction-level reference model.
// Lock scenario is exercised when ARB_LOCK_EN is defined.
module tb_alu_rr_arbiter;
  localparam int TO_P = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_arb_if bus ();

  alu_rr_arbiter #(.TIMEOUT(TO_P), .TO_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // observed = {sel, gnt, alu_start, busy, timeout_err}
  wire [8:0] obs = {bus.sel, bus.gnt, bus.alu_start, bus.busy, bus.timeout_err};

  // reference model: phase 0 idle, 1 start, 2 wait
  int         m_phase, m_ptr, m_owner, m_waits;
  logic       m_err;
  logic [8:0] exp_v;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    bus.alu_done = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock = 4'b0000;
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_phase = 0; m_ptr = 0; m_owner = 0; m_waits = 0; m_err = 1'b0;
  endtask

  task automatic model_arbitrate(input logic [3:0] r);
    m_phase = 0;
    for (int i = 3; i >= 0; i--) begin
      if (r[(m_ptr + i) % 4]) begin
        m_owner = (m_ptr + i) % 4;
        m_phase = 1;
      end
    end
  endtask

  // advance the model across one clock edge given the current inputs
  task automatic model_step(input logic [3:0] r, input logic d, input logic [3:0] lk);
    m_err = 1'b0;
    if (m_phase == 1) begin
      m_phase = 2;
      m_waits = 0;
    end else if (m_phase == 2) begin
      m_waits++;
      if (d) begin
        if (lk[m_owner] && r[m_owner]) begin
          m_phase = 1;
        end else begin
          m_ptr = (m_owner + 1) % 4;
          model_arbitrate(r);
        end
      end else if (TO_P != 0 && m_waits == TO_P) begin
        m_err = 1'b1;
        m_ptr = (m_owner + 1) % 4;
        model_arbitrate(r);
      end
    end else begin
      model_arbitrate(r);
    end
    exp_v = {2'(m_owner), (m_phase != 0) ? (4'b0001 << m_owner) : 4'b0000,
             (m_phase == 1), (m_phase != 0), m_err};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 4'b0000;
    bus.alu_done = 1'b0;
`ifdef ARB_LOCK_EN
    bus.lock = 4'b0000;
`endif
    #2;
    checks++;
    if (obs !== 9'b0) begin errors++; $display("FAIL reset_idle got %b exp %b", obs, 9'b0); end
    step();
    rst_n = 1'b1;
    bus.req = 4'b1000;
    step();
    step();
    step();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_prewait busy got %b exp 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 9'b0) begin errors++; $display("FAIL reset_midwait got %b exp %b", obs, 9'b0); end
    step();
    rst_n = 1'b1;
    bus.req = 4'b0100;
    step();
    checks++;
    if (obs !== {2'b10, 4'b0100, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL reset_regrant got %b exp %b", obs, {2'b10, 4'b0100, 3'b110});
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001;
    step();
    checks++;
    if (obs !== {2'b00, 4'b0001, 3'b110}) begin errors++; $display("FAIL single_start got %b exp %b", obs, {2'b00, 4'b0001, 3'b110}); end
    bus.req = 4'b0000;
    step();
    step();
    checks++;
    if (obs !== {2'b00, 4'b0001, 3'b010}) begin errors++; $display("FAIL single_wait got %b exp %b", obs, {2'b00, 4'b0001, 3'b010}); end
    bus.alu_done = 1'b1;
    step();
    bus.alu_done = 1'b0;
    checks++;
    if (obs !== {2'b00, 4'b0000, 3'b000}) begin errors++; $display("FAIL single_done got %b exp %b", obs, {2'b00, 4'b0000, 3'b000}); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] eg;
    do_reset();
    bus.req = 4'b1111;
    step();
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      checks++;
      if (obs !== {2'(k % 4), eg, 3'b110}) begin
        errors++; $display("FAIL b2b_start%0d got %b exp %b", k, obs, {2'(k % 4), eg, 3'b110});
      end
      step();
      checks++;
      if (obs !== {2'(k % 4), eg, 3'b010}) begin
        errors++; $display("FAIL b2b_wait%0d got %b exp %b", k, obs, {2'(k % 4), eg, 3'b010});
      end
      bus.alu_done = 1'b1;
      step();
      bus.alu_done = 1'b0;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    for (int k = 1; k <= TO_P; k++) begin
      step();
      checks++;
      if (obs !== {2'b01, 4'b0010, 3'b010}) begin
        errors++; $display("FAIL to_wait%0d got %b exp %b", k, obs, {2'b01, 4'b0010, 3'b010});
      end
    end
    step();
    checks++;
    if (obs !== {2'b01, 4'b0000, 3'b001}) begin errors++; $display("FAIL to_err got %b exp %b", obs, {2'b01, 4'b0000, 3'b001}); end
    step();
    checks++;
    if (obs !== {2'b01, 4'b0000, 3'b000}) begin errors++; $display("FAIL to_errpulse got %b exp %b", obs, {2'b01, 4'b0000, 3'b000}); end
    bus.req = 4'b0110;
    step();
    checks++;
    if (obs !== {2'b10, 4'b0100, 3'b110}) begin errors++; $display("FAIL to_ptr got %b exp %b", obs, {2'b10, 4'b0100, 3'b110}); end
  endtask

  task automatic test_done_vs_timeout();
    do_reset();
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    for (int k = 1; k <= TO_P; k++) step();
    bus.alu_done = 1'b1;
    step();
    bus.alu_done = 1'b0;
    checks++;
    if (obs !== {2'b01, 4'b0000, 3'b000}) begin errors++; $display("FAIL done_vs_to got %b exp %b", obs, {2'b01, 4'b0000, 3'b000}); end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    bus.req = 4'b0011;
    bus.lock = 4'b0001;
    step();
    step();
    bus.alu_done = 1'b1;
    step();
    bus.alu_done = 1'b0;
    checks++;
    if (obs !== {2'b00, 4'b0001, 3'b110}) begin errors++; $display("FAIL lock_regrant got %b exp %b", obs, {2'b00, 4'b0001, 3'b110}); end
    bus.lock = 4'b0000;
    step();
    bus.alu_done = 1'b1;
    step();
    bus.alu_done = 1'b0;
    checks++;
    if (obs !== {2'b01, 4'b0010, 3'b110}) begin errors++; $display("FAIL lock_release got %b exp %b", obs, {2'b01, 4'b0010, 3'b110}); end
  endtask
`endif

  task automatic test_random();
    logic [3:0] lk;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus.req = 4'($urandom);
      if ($urandom_range(0, 2) == 0) bus.req = 4'b0000;
      bus.alu_done = ($urandom_range(0, 5) == 0);
      lk = 4'b0000;
`ifdef ARB_LOCK_EN
      bus.lock = 4'($urandom);
      lk = bus.lock;
`endif
      model_step(bus.req, bus.alu_done, lk);
      step();
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL random_cyc%0d got %b exp %b", n, obs, exp_v);
      end
    end
    bus.alu_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_done_vs_timeout();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
